wb_sram_responder: RTL and testbench

Wishbone B4 pipelined responder that serves single-beat read/write requests from the bus arbiter by driving an external asynchronous SRAM with a fixed, parameterised number of wait states. It sits between the arbiter's responder port and the board SRAM pins. It is the target side for the video fetch initiator, the CPU bridge and the MCU bridge.

---
 rtl/wb_sram_responder_if.sv | 36 +++
 rtl/wb_sram_responder.sv | 166 ++++++++++++++++
 tb/tb_wb_sram_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_responder_if.sv
// Bus bundle between the arbiter responder port, this block and the SRAM pins.
interface wb_sram_responder_if #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_WIDTH = 17
);
    logic [WB_ADDR_WIDTH-1:0]  wb_addr_i;
    logic [DATA_WIDTH-1:0]     wb_data_i;
    logic [DATA_WIDTH-1:0]     wb_data_o;
    logic                      wb_we_i;
    logic                      wb_cycle_i;
    logic                      wb_strobe_i;
    logic                      wb_stall_o;
    logic                      wb_ack_o;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0]     ram_data_i;
    logic [DATA_WIDTH-1:0]     ram_data_o;
    logic                      ram_data_oe_o;
    logic                      ram_ce_no;
    logic                      ram_oe_no;
    logic                      ram_we_no;

    // Responder side: takes Wishbone requests, drives the SRAM pins.
    modport slave (
        input  wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i, ram_data_i,
        output wb_data_o, wb_stall_o, wb_ack_o,
        output ram_addr_o, ram_data_o, ram_data_oe_o, ram_ce_no, ram_oe_no, ram_we_no
    );

    // Opposite side: the initiator plus the SRAM model.
    modport master (
        output wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i, ram_data_i,
        input  wb_data_o, wb_stall_o, wb_ack_o,
        input  ram_addr_o, ram_data_o, ram_data_oe_o, ram_ce_no, ram_oe_no, ram_we_no
    );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone B4 pipelined responder driving an asynchronous SRAM with fixed wait states.
module wb_sram_responder #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned WAIT_STATES    = 2
) (
    input  logic                 wb_clock_i,
    input  logic                 wb_reset_ni,
    wb_sram_responder_if.slave   bus
);
    localparam int unsigned CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_COMPLETE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      r_we;
    logic                      w_we_nxt;
    logic                      r_abort;
    logic                      w_abort_nxt;
    logic                      w_accept;
    logic                      w_capture;

    logic                      r_stall;
    logic                      r_ack;
    logic                      r_ce_n;
    logic                      r_oe_n;
    logic                      r_we_n;
    logic                      r_data_oe;
    logic                      w_stall_nxt;
    logic                      w_ack_nxt;
    logic                      w_ce_n_nxt;
    logic                      w_oe_n_nxt;
    logic                      w_we_n_nxt;
    logic                      w_data_oe_nxt;

    logic [RAM_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_rdata;

    // Upper Wishbone address bits do not reach the SRAM.
    if (WB_ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_addr_unused
        logic w_unused_addr;
        assign w_unused_addr = ^bus.wb_addr_i[WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH];
    end

    assign w_accept = bus.wb_cycle_i && bus.wb_strobe_i && !r_stall;

    // Next state, counter, abort tracking and registered pin values.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_we_nxt      = r_we;
        w_abort_nxt   = r_abort;
        w_capture     = 1'b0;
        w_stall_nxt   = 1'b0;
        w_ack_nxt     = 1'b0;
        w_ce_n_nxt    = 1'b1;
        w_oe_n_nxt    = 1'b1;
        w_we_n_nxt    = 1'b1;
        w_data_oe_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_COMPLETE: begin
                if (w_accept) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = CNT_W'(WAIT_STATES);
                    w_we_nxt    = bus.wb_we_i;
                    w_abort_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (!bus.wb_cycle_i) begin
                    w_abort_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = S_COMPLETE;
                    w_capture   = !r_we;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Pins are decoded from the state being entered so they come straight from flops.
        case (w_state_nxt)
            S_ACCESS: begin
                w_stall_nxt   = 1'b1;
                w_ce_n_nxt    = 1'b0;
                w_oe_n_nxt    = w_we_nxt;
                w_we_n_nxt    = !w_we_nxt;
                w_data_oe_nxt = w_we_nxt;
            end
            S_COMPLETE: begin
                w_data_oe_nxt = w_we_nxt;
                w_ack_nxt     = !w_abort_nxt;
            end
            default: ;
        endcase
    end

    // State and control register; reset forces the SRAM strobes inactive immediately.
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_abort   <= 1'b0;
            r_stall   <= 1'b0;
            r_ack     <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_we      <= w_we_nxt;
            r_abort   <= w_abort_nxt;
            r_stall   <= w_stall_nxt;
            r_ack     <= w_ack_nxt;
            r_ce_n    <= w_ce_n_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_we_n    <= w_we_n_nxt;
            r_data_oe <= w_data_oe_nxt;
        end
    end

    // Address/write data latch on accept, read data capture at the end of ACCESS.
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.wb_addr_i[RAM_ADDR_WIDTH-1:0];
                r_wdata <= bus.wb_data_i;
            end
            if (w_capture) begin
                r_rdata <= bus.ram_data_i;
            end
        end
    end

    assign bus.wb_data_o     = r_rdata;
    assign bus.wb_stall_o    = r_stall;
    assign bus.wb_ack_o      = r_ack;
    assign bus.ram_addr_o    = r_addr;
    assign bus.ram_data_o    = r_wdata;
    assign bus.ram_data_oe_o = r_data_oe;
    assign bus.ram_ce_no     = r_ce_n;
    assign bus.ram_oe_no     = r_oe_n;
    assign bus.ram_we_no     = r_we_n;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed bench for wb_sram_responder at WAIT_STATES=2.
module tb_wb_sram_responder;
    localparam int unsigned WB_AW = 32;
    localparam int unsigned DW    = 8;
    localparam int unsigned RAW   = 17;
    localparam int unsigned WS    = 2;

    // {stall, ack, wb_data_o, ram_addr_o, ram_data_o, data_oe, ce_n, oe_n, we_n}
    localparam logic [38:0] RST_VEC = {1'b0, 1'b0, 8'h00, 17'h00000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    wb_sram_responder_if #(.WB_ADDR_WIDTH(WB_AW), .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(RAW)) bus ();

    wb_sram_responder #(
        .WB_ADDR_WIDTH (WB_AW),
        .DATA_WIDTH    (DW),
        .RAM_ADDR_WIDTH(RAW),
        .WAIT_STATES   (WS)
    ) dut (
        .wb_clock_i (clk),
        .wb_reset_ni(rst_n),
        .bus        (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [38:0] obs;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.wb_addr_i   = $urandom;
            bus.wb_data_i   = DW'($urandom);
            bus.wb_we_i     = 1'($urandom);
            bus.wb_cycle_i  = 1'($urandom);
            bus.wb_strobe_i = 1'($urandom);
            bus.ram_data_i  = DW'($urandom);
            tick();
            obs = {bus.wb_stall_o, bus.wb_ack_o, bus.wb_data_o, bus.ram_addr_o, bus.ram_data_o,
                   bus.ram_data_oe_o, bus.ram_ce_no, bus.ram_oe_no, bus.ram_we_no};
            checks++;
            if (obs !== RST_VEC) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, obs, RST_VEC);
            end
        end
        bus.wb_cycle_i  = 1'b0;
        bus.wb_strobe_i = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            obs = {bus.wb_stall_o, bus.wb_ack_o, bus.wb_data_o, bus.ram_addr_o, bus.ram_data_o,
                   bus.ram_data_oe_o, bus.ram_ce_no, bus.ram_oe_no, bus.ram_we_no};
            checks++;
            if (obs !== RST_VEC) begin
                failures++;
                $display("FAIL reset_idle[%0d] got=%h exp=%h", i, obs, RST_VEC);
            end
        end
    endtask

    task automatic test_strobe_no_cycle;
        int busy;
        busy = 0;
        bus.wb_addr_i   = 32'h0000_0077;
        bus.wb_we_i     = 1'b0;
        bus.wb_cycle_i  = 1'b0;
        bus.wb_strobe_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.wb_stall_o || !bus.ram_ce_no || bus.wb_ack_o) busy++;
        end
        bus.wb_strobe_i = 1'b0;
        checks++;
        if (busy !== 0) begin
            failures++;
            $display("FAIL strobe_no_cycle busy_cycles got=%0d exp=0", busy);
        end
    endtask

    task automatic test_read;
        int oe_low, stall_hi, acks, ack_at;
        logic [DW-1:0] dat;
        logic [RAW-1:0] addr0;
        oe_low = 0; stall_hi = 0; acks = 0; ack_at = -1; dat = '0; addr0 = '0;
        bus.wb_addr_i   = 32'h0000_1234;
        bus.wb_we_i     = 1'b0;
        bus.ram_data_i  = 8'hA5;
        bus.wb_cycle_i  = 1'b1;
        bus.wb_strobe_i = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 0) begin
                bus.wb_strobe_i = 1'b0;
                addr0 = bus.ram_addr_o;
            end
            if (!bus.ram_oe_no) oe_low++;
            if (bus.wb_stall_o) stall_hi++;
            if (bus.wb_ack_o) begin
                acks++;
                ack_at = e;
                dat = bus.wb_data_o;
            end
        end
        bus.wb_cycle_i = 1'b0;
        checks++;
        if (addr0 !== 17'h01234) begin failures++; $display("FAIL read_addr got=%h exp=01234", addr0); end
        checks++;
        if (oe_low !== 3) begin failures++; $display("FAIL read_oe_cycles got=%0d exp=3", oe_low); end
        checks++;
        if (stall_hi !== 3) begin failures++; $display("FAIL read_stall_cycles got=%0d exp=3", stall_hi); end
        checks++;
        if (acks !== 1) begin failures++; $display("FAIL read_ack_count got=%0d exp=1", acks); end
        checks++;
        if (ack_at !== 3) begin failures++; $display("FAIL read_ack_cycle got=%0d exp=3", ack_at); end
        checks++;
        if (dat !== 8'hA5) begin failures++; $display("FAIL read_data got=%h exp=a5", dat); end
    endtask

    task automatic test_write;
        int we_low, doe_hi, acks, ack_at;
        we_low = 0; doe_hi = 0; acks = 0; ack_at = -1;
        bus.wb_addr_i   = 32'h0001_FFFF;
        bus.wb_data_i   = 8'h3C;
        bus.wb_we_i     = 1'b1;
        bus.wb_cycle_i  = 1'b1;
        bus.wb_strobe_i = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 0) bus.wb_strobe_i = 1'b0;
            if (!bus.ram_we_no && bus.ram_addr_o == 17'h1FFFF) we_low++;
            if (bus.ram_data_oe_o && bus.ram_data_o == 8'h3C) doe_hi++;
            if (bus.wb_ack_o) begin
                acks++;
                ack_at = e;
            end
        end
        bus.wb_cycle_i = 1'b0;
        checks++;
        if (we_low !== 3) begin failures++; $display("FAIL write_we_cycles got=%0d exp=3", we_low); end
        checks++;
        if (doe_hi !== 4) begin failures++; $display("FAIL write_data_oe_cycles got=%0d exp=4", doe_hi); end
        checks++;
        if (acks !== 1) begin failures++; $display("FAIL write_ack_count got=%0d exp=1", acks); end
        checks++;
        if (ack_at !== 3) begin failures++; $display("FAIL write_ack_cycle got=%0d exp=3", ack_at); end
        checks++;
        if (bus.wb_data_o !== 8'hA5) begin failures++; $display("FAIL write_keeps_rdata got=%h exp=a5", bus.wb_data_o); end
    endtask

    task automatic test_back_to_back;
        logic [31:0]    r_addr[3];
        logic           r_we[3];
        logic [DW-1:0]  r_val[3];
        int             acc_edge[3];
        int             ack_edge[3];
        logic [RAW-1:0] ack_addr[3];
        logic [DW-1:0]  ack_rd[3];
        logic [DW-1:0]  ack_wd[3];
        int idx, nack;
        logic acc;
        r_addr = '{32'h10, 32'h11, 32'h12};
        r_we   = '{1'b0, 1'b1, 1'b0};
        r_val  = '{8'h5A, 8'hE7, 8'hC3};
        for (int k = 0; k < 3; k++) begin
            acc_edge[k] = -1; ack_edge[k] = -1;
            ack_addr[k] = '0; ack_rd[k] = '0; ack_wd[k] = '0;
        end
        idx = 0; nack = 0;
        bus.wb_addr_i   = r_addr[0];
        bus.wb_we_i     = r_we[0];
        bus.ram_data_i  = r_val[0];
        bus.wb_cycle_i  = 1'b1;
        bus.wb_strobe_i = 1'b1;
        for (int e = 0; e < 16; e++) begin
            acc = bus.wb_cycle_i && bus.wb_strobe_i && !bus.wb_stall_o;
            tick();
            if (acc && idx < 3) begin
                acc_edge[idx] = e;
                idx++;
                if (idx < 3) begin
                    bus.wb_addr_i = r_addr[idx];
                    bus.wb_we_i   = r_we[idx];
                    if (r_we[idx]) bus.wb_data_i = r_val[idx];
                    else           bus.ram_data_i = r_val[idx];
                end else begin
                    bus.wb_strobe_i = 1'b0;
                end
            end
            if (bus.wb_ack_o) begin
                if (nack < 3) begin
                    ack_edge[nack] = e;
                    ack_addr[nack] = bus.ram_addr_o;
                    ack_rd[nack]   = bus.wb_data_o;
                    ack_wd[nack]   = bus.ram_data_o;
                end
                nack++;
            end
        end
        bus.wb_cycle_i = 1'b0;
        checks++;
        if (nack !== 3) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=3", nack); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (acc_edge[k] !== 4 * k) begin
                failures++; $display("FAIL b2b_accept_edge[%0d] got=%0d exp=%0d", k, acc_edge[k], 4 * k);
            end
            checks++;
            if (ack_edge[k] !== 4 * k + 3) begin
                failures++; $display("FAIL b2b_ack_edge[%0d] got=%0d exp=%0d", k, ack_edge[k], 4 * k + 3);
            end
            checks++;
            if (ack_addr[k] !== RAW'(r_addr[k])) begin
                failures++; $display("FAIL b2b_ack_addr[%0d] got=%h exp=%h", k, ack_addr[k], RAW'(r_addr[k]));
            end
        end
        checks++;
        if (ack_rd[0] !== 8'h5A) begin failures++; $display("FAIL b2b_read0_data got=%h exp=5a", ack_rd[0]); end
        checks++;
        if (ack_wd[1] !== 8'hE7) begin failures++; $display("FAIL b2b_write1_data got=%h exp=e7", ack_wd[1]); end
        checks++;
        if (ack_rd[2] !== 8'hC3) begin failures++; $display("FAIL b2b_read2_data got=%h exp=c3", ack_rd[2]); end
    endtask

    task automatic test_abort;
        int we_low, acks, ack_at;
        logic [DW-1:0] dat;
        we_low = 0; acks = 0;
        bus.wb_addr_i   = 32'h0000_0055;
        bus.wb_data_i   = 8'h77;
        bus.wb_we_i     = 1'b1;
        bus.wb_cycle_i  = 1'b1;
        bus.wb_strobe_i = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 0) begin
                bus.wb_strobe_i = 1'b0;
                bus.wb_cycle_i  = 1'b0;
            end
            if (!bus.ram_we_no) we_low++;
            if (bus.wb_ack_o) acks++;
        end
        checks++;
        if (we_low !== 3) begin failures++; $display("FAIL abort_we_cycles got=%0d exp=3", we_low); end
        checks++;
        if (acks !== 0) begin failures++; $display("FAIL abort_ack_count got=%0d exp=0", acks); end

        acks = 0; ack_at = -1; dat = '0;
        bus.wb_addr_i   = 32'h0000_0100;
        bus.wb_we_i     = 1'b0;
        bus.ram_data_i  = 8'h9E;
        bus.wb_cycle_i  = 1'b1;
        bus.wb_strobe_i = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 0) bus.wb_strobe_i = 1'b0;
            if (bus.wb_ack_o) begin
                acks++;
                ack_at = e;
                dat = bus.wb_data_o;
            end
        end
        bus.wb_cycle_i = 1'b0;
        checks++;
        if (acks !== 1 || ack_at !== 3) begin
            failures++; $display("FAIL post_abort_ack count=%0d cycle=%0d exp count=1 cycle=3", acks, ack_at);
        end
        checks++;
        if (dat !== 8'h9E) begin failures++; $display("FAIL post_abort_data got=%h exp=9e", dat); end
    endtask

    task automatic test_async_reset;
        int acks;
        logic [3:0] pins;
        acks = 0;
        bus.wb_addr_i   = 32'h0000_0ABC;
        bus.wb_data_i   = 8'h42;
        bus.wb_we_i     = 1'b1;
        bus.wb_cycle_i  = 1'b1;
        bus.wb_strobe_i = 1'b1;
        tick();
        bus.wb_strobe_i = 1'b0;
        tick();
        checks++;
        if (bus.ram_we_no !== 1'b0 || bus.ram_data_oe_o !== 1'b1) begin
            failures++; $display("FAIL arst_pre_write we_n=%b data_oe=%b exp we_n=0 data_oe=1",
                                 bus.ram_we_no, bus.ram_data_oe_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        pins = {bus.ram_we_no, bus.ram_ce_no, bus.ram_oe_no, bus.ram_data_oe_o};
        checks++;
        if (pins !== 4'b1110) begin
            failures++; $display("FAIL arst_pins {we_n,ce_n,oe_n,data_oe} got=%b exp=1110", pins);
        end
        checks++;
        if (bus.wb_stall_o !== 1'b0 || bus.wb_ack_o !== 1'b0) begin
            failures++; $display("FAIL arst_bus stall=%b ack=%b exp 0 0", bus.wb_stall_o, bus.wb_ack_o);
        end
        tick();
        tick();
        bus.wb_cycle_i = 1'b0;
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (bus.wb_ack_o || !bus.ram_ce_no) acks++;
        end
        checks++;
        if (acks !== 0) begin failures++; $display("FAIL arst_after_release activity got=%0d exp=0", acks); end
        checks++;
        if (bus.wb_data_o !== 8'h00) begin failures++; $display("FAIL arst_rdata got=%h exp=00", bus.wb_data_o); end
    endtask

    initial begin
        bus.wb_addr_i   = '0;
        bus.wb_data_i   = '0;
        bus.wb_we_i     = 1'b0;
        bus.wb_cycle_i  = 1'b0;
        bus.wb_strobe_i = 1'b0;
        bus.ram_data_i  = '0;
        test_reset();
        test_strobe_no_cycle();
        test_read();
        test_write();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
